fir_out_buffer: RTL and testbench

Elastic output buffer placed directly downstream of the FIR filter. It captures every valid filter sample (`dout`/`vout` of the filter), with no back-pressure to the filter. It then presents the samples in order to the data sink through a valid/ready handshake. Samples that arrive while the buffer is full are dropped and counted, and a sticky flag records the overflow.

---
 rtl/fir_pkg.sv | 10 +
 rtl/fir_buf_mem.sv | 26 ++
 rtl/fir_out_buffer.sv | 114 +++++++++++
 tb/tb_fir_out_buffer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR constants and sizing helpers
package fir_pkg;

  localparam int FIR_DATA_W = 8;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fir_buf_mem.sv
// rtl/fir_buf_mem.sv - sample storage array, synchronous write, asynchronous read
module fir_buf_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // Contents are intentionally never reset; only the pointers around them are.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fir_out_buffer.sv
// rtl/fir_out_buffer.sv - elastic FWFT output buffer behind the FIR, drops and counts on overflow
module fir_out_buffer
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        din,
  input  logic                     vin,
  input  logic                     clr,
  output logic [DATA_W-1:0]        dout,
  output logic                     vout,
  input  logic                     rdy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     ovf,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic pop;
  logic push;
  logic drop;
  logic is_full;
  logic not_empty;

  assign not_empty = (count_q != '0);
  assign is_full   = (count_q == CW'(DEPTH));

  // A flush suppresses both sides, so neither a pop nor a drop is seen that cycle.
  assign pop  = not_empty && rdy && !clr;
  assign push = vin && !clr && (!is_full || pop);
  assign drop = vin && !clr && is_full && !pop;

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (clr) begin
      wp_d       = '0;
      rp_d       = '0;
      count_d    = '0;
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push) begin
        wp_d = wp_q + PW'(1);
      end
      if (pop) begin
        rp_d = rp_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_cnt_q != '1) begin
          drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fir_buf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wp_q),
    .wdata (din),
    .raddr (rp_q),
    .rdata (dout)
  );

  assign vout     = not_empty;
  assign full     = is_full;
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_fir_out_buffer.sv
// tb/tb_fir_out_buffer.sv - scoreboard bench for fir_out_buffer
module tb_fir_out_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       vin;
  logic       clr;
  logic [7:0] dout;
  logic       vout;
  logic       rdy;
  logic [3:0] count;
  logic       full;
  logic       ovf;
  logic [7:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];

  fir_out_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .vin      (vin),
    .clr      (clr),
    .dout     (dout),
    .vout     (vout),
    .rdy      (rdy),
    .count    (count),
    .full     (full),
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] d);
    vin = 1'b1;
    din = d;
    exp_q.push_back(d);
    tick();
  endtask

  // Any accepted output must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst && vout && rdy && !clr) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got 0x%0h, expected no output at %0t", dout, $time);
      end else begin
        chk("dout", int'(dout), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b0;
    din = 8'h00;
    vin = 1'b0;
    clr = 1'b0;
    rdy = 1'b1;

    // reset and latency
    repeat (3) tick();
    chk("rst_vout", vout, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_full", full, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b1;
    tick();
    vin = 1'b1;
    din = 8'h5A;
    exp_q.push_back(8'h5A);
    chk("lat_vout_n", vout, 0);
    tick();
    vin = 1'b0;
    chk("lat_vout_n1", vout, 1);
    chk("lat_count_n1", count, 1);
    tick();
    chk("lat_vout_n2", vout, 0);
    chk("lat_count_n2", count, 0);

    // stall and fill
    rdy = 1'b0;
    for (int i = 1; i <= 8; i++) push_exp(8'(i));
    vin = 1'b0;
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);

    // overflow while stalled
    vin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 8'hE0 + 8'(i);
      tick();
    end
    vin = 1'b0;
    chk("ovf_drop", drop_cnt, 3);
    chk("ovf_flag", ovf, 1);
    chk("ovf_count", count, 8);

    // full with simultaneous push and pop
    rdy = 1'b1;
    vin = 1'b1;
    din = 8'h99;
    exp_q.push_back(8'h99);
    chk("pp_vout", vout, 1);
    tick();
    vin = 1'b0;
    chk("pp_count", count, 8);
    chk("pp_drop", drop_cnt, 3);
    for (int i = 0; i < 8; i++) begin
      chk("drain_vout", vout, 1);
      tick();
    end
    chk("drain_empty", vout, 0);
    chk("drain_count", count, 0);
    chk("drain_ovf_sticky", ovf, 1);
    chk("drain_drop", drop_cnt, 3);

    // flush clears flags, then build count=5 / drop_cnt=2
    rdy = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ovf", ovf, 0);
    chk("clr_drop", drop_cnt, 0);
    for (int i = 0; i < 8; i++) push_exp(8'h31 + 8'(i));
    din = 8'hE5;
    vin = 1'b1;
    repeat (2) tick();
    vin = 1'b0;
    rdy = 1'b1;
    repeat (3) tick();
    rdy = 1'b0;
    chk("pre_flush_count", count, 5);
    chk("pre_flush_drop", drop_cnt, 2);
    clr = 1'b1;
    vin = 1'b1;
    din = 8'h77;
    rdy = 1'b1;
    exp_q.delete();
    tick();
    clr = 1'b0;
    vin = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_vout", vout, 0);
    chk("flush_drop", drop_cnt, 0);
    chk("flush_ovf", ovf, 0);
    repeat (3) tick();
    chk("flush_no77", vout, 0);

    // ramp stream across pointer wrap, rdy toggling, reset mid-stream
    for (int c = 0; c < 40; c++) begin
      vin = (c % 2 == 0);
      din = 8'hA0 + 8'(c / 2);
      rdy = (c % 2 == 0);
      if (vin) exp_q.push_back(din);
      if (c == 34) begin
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("amid_vout", vout, 0);
        chk("amid_count", count, 0);
        chk("amid_full", full, 0);
        chk("amid_ovf", ovf, 0);
        chk("amid_drop", drop_cnt, 0);
        vin = 1'b0;
        tick();
        rst = 1'b1;
        break;
      end
      tick();
    end
    vin = 1'b0;
    rdy = 1'b1;
    tick();
    vin = 1'b1;
    din = 8'hC3;
    exp_q.push_back(8'hC3);
    tick();
    vin = 1'b0;
    chk("post_rst_vout", vout, 1);
    chk("post_rst_count", count, 1);
    tick();
    chk("post_rst_empty", vout, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
